// File: rtl/uib_arbiter_pkg.sv
// rtl/uib_arbiter_pkg.sv - shared UIB bus types and constants
package uib_arbiter_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;

  typedef enum logic {
    MST_LSU = 1'b0,
    MST_IFU = 1'b1
  } mst_id_e;

  typedef struct packed {
    logic    valid;
    mst_id_e id;
  } owner_t;

endpackage

// File: rtl/uib_arb_pick.sv
// rtl/uib_arb_pick.sv - fixed-priority grant with starvation override
module uib_arb_pick #(
  parameter int MAX_WAIT = 4
) (
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic [3:0] wait_cnt,
  output logic       m0_gnt,
  output logic       m1_gnt
);

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    // Grants are suppressed during reset so no slave access is launched.
    if (!rst) begin
      if (m1_req && (!m0_req || wait_cnt == 4'(MAX_WAIT))) begin
        m1_gnt = 1'b1;
      end else if (m0_req) begin
        m0_gnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uib_arbiter.sv
// rtl/uib_arbiter.sv - two-master UIB arbiter with response routing
module uib_arbiter #(
  parameter int XLEN     = uib_arbiter_pkg::XLEN,
  parameter int AW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_wen,
  input  logic [AW-1:0]   m0_addr,
  input  logic [1:0]      m0_mode,
  input  logic [XLEN-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_ack,
  output logic [XLEN-1:0] m0_rdata,
  input  logic            m1_req,
  input  logic            m1_wen,
  input  logic [AW-1:0]   m1_addr,
  input  logic [1:0]      m1_mode,
  input  logic [XLEN-1:0] m1_wdata,
  output logic            m1_gnt,
  output logic            m1_ack,
  output logic [XLEN-1:0] m1_rdata,
  output logic            bus_req,
  output logic            bus_wen,
  output logic [AW-1:0]   bus_addr,
  output logic [1:0]      bus_mode,
  output logic [XLEN-1:0] bus_dat_i,
  input  logic [XLEN-1:0] bus_dat_o
);
  import uib_arbiter_pkg::*;

  logic [3:0] wait_cnt;
  owner_t     owner;

  uib_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .rst      (rst),
    .m0_req   (m0_req),
    .m1_req   (m1_req),
    .wait_cnt (wait_cnt),
    .m0_gnt   (m0_gnt),
    .m1_gnt   (m1_gnt)
  );

  always_comb begin
    bus_req   = m0_gnt | m1_gnt;
    bus_wen   = 1'b0;
    bus_addr  = '0;
    bus_mode  = '0;
    bus_dat_i = '0;
    if (m1_gnt) begin
      bus_wen   = m1_wen;
      bus_addr  = m1_addr;
      bus_mode  = m1_mode;
      bus_dat_i = m1_wdata;
    end else if (m0_gnt) begin
      bus_wen   = m0_wen;
      bus_addr  = m0_addr;
      bus_mode  = m0_mode;
      bus_dat_i = m0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
      owner    <= '0;
    end else begin
      if (!m1_req || m1_gnt) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != 4'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
      owner.valid <= m0_gnt | m1_gnt;
      owner.id    <= m1_gnt ? MST_IFU : MST_LSU;
    end
  end

  // The slave answers one cycle after acceptance; only the owner sees it.
  assign m0_ack   = owner.valid && (owner.id == MST_LSU);
  assign m1_ack   = owner.valid && (owner.id == MST_IFU);
  assign m0_rdata = m0_ack ? bus_dat_o : '0;
  assign m1_rdata = m1_ack ? bus_dat_o : '0;

endmodule

// File: doc/uib_arbiter.md
Name: uib_arbiter

Overview:
- Two-master to one-slave arbiter on the UIB bus, directly upstream of the main memory slave.
- Master 0 is the load/store port; master 1 is the instruction-fetch port.
- Grants at most one transaction per cycle to the slave and routes the slave's 1-cycle-latency response back to the owning master.
- Fixed priority to master 0, with an anti-starvation counter that forces a master 1 grant after a bounded wait.

Parameters:
- XLEN, 32, data width of all bus data ports.
- AW, 32, address width.
- MAX_WAIT, 4, consecutive cycles master 1 may be denied while requesting before it is forced ahead of master 0 (1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held until m0_gnt.
- m0_wen  in  1  master 0 write enable (valid with m0_req).
- m0_addr  in  AW  master 0 byte address.
- m0_mode  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- m0_wdata  in  XLEN  master 0 write data.
- m0_gnt  out  1  master 0 request accepted this cycle.
- m0_ack  out  1  response for the previously accepted m0 transaction.
- m0_rdata  out  XLEN  read data, valid when m0_ack and the transaction was a read.
- m1_req, m1_wen, m1_addr, m1_mode, m1_wdata, m1_gnt, m1_ack, m1_rdata: identical for master 1.
- bus_req  out  1  slave request.
- bus_wen  out  1  slave write enable.
- bus_addr  out  AW  slave address.
- bus_mode  out  2  slave access size.
- bus_dat_i  out  XLEN  data to slave.
- bus_dat_o  in  XLEN  data from slave, valid 1 cycle after an accepted request.

Behaviour:
- Arbitration (combinational, same cycle):
  - Only m0 requests: grant m0.
  - Only m1 requests: grant m1.
  - Both request: grant m0, unless wait_cnt == MAX_WAIT, then grant m1.
- Exactly one of m0_gnt/m1_gnt is high when any request is present; neither is high when none is.
- Slave side: bus_req = m0_gnt | m1_gnt. bus_wen/addr/mode/dat_i are muxed from the granted master. When no grant, bus_req = 0, bus_wen = 0, and all other bus outputs are 0.
- wait_cnt (4-bit register):
  - Increments when m1_req is high and m1_gnt is low, saturating at MAX_WAIT.
  - Clears when m1_gnt is high or m1_req is low.
- Response routing:
  - Registered owner (2 bits: valid, id) captures the grant each cycle.
  - Next cycle, ack is raised for owner.id only: mN_ack = owner.valid & (owner.id == N).
  - mN_rdata = bus_dat_o when mN_ack, else 0.
- Latency: request granted in cycle T; ack and rdata at cycle T+1. Back-to-back grants give one ack per cycle, including interleaved m0/m1 traffic.
- Writes: ack is still issued at T+1; rdata content is slave-defined and ignored by the master.
- Mode 11: forwarded unchanged; the arbiter does no checking.
- Reset (sync, rst high at an edge):
  - owner.valid = 0 and wait_cnt = 0.
  - m0_ack and m1_ack are 0 in the following cycle.
  - An ack owed for a transaction granted in the reset cycle is dropped.
- While rst is high, gnt outputs and bus_req are forced 0 (combinationally gated), so no slave access is launched during reset.
- Reset values of all outputs: gnt 0, ack 0, rdata 0, bus_req 0, bus_wen 0, bus_addr 0, bus_mode 0, bus_dat_i 0.
- Master deasserting req without a grant is legal; no state changes other than wait_cnt clearing.

Decomposition:
- Shared bus package holds:
  - mode encodings (MODE_BYTE=2'b00, MODE_HALF=2'b01, MODE_WORD=2'b10);
  - XLEN;
  - a master-id enum (MST_LSU=0, MST_IFU=1);
  - the owner struct {valid, id}.
- One sub-module is natural: uib_arb_pick, the combinational priority/starvation grant logic with wait_cnt as an input. Response routing and the counter stay in uib_arbiter.

Test Plan:
- Single read: m0_req=1, m0_addr=0x10, m0_mode=10, rd, with slave returning 0xDEADBEEF -> m0_gnt at T, bus_addr=0x10, m0_ack=1 and m0_rdata=0xDEADBEEF at T+1; m1_ack stays 0.
- Contention: both request continuously, MAX_WAIT=4 -> grant sequence m0,m0,m0,m0,m1,m0,m0,m0,m0,m1; wait_cnt peaks at 4.
- Interleave: m0 write 0x1234 at 0x20 at T, m1 read 0x20 at T+1 -> bus_wen=1 at T; m0_ack at T+1; m1_ack with slave data 0x1234 at T+2.
- Idle/withdraw: m1_req high 2 cycles under m0 load, then low -> wait_cnt 1,2,0; no m1_gnt and no m1_ack.
- Reset mid-op: m0 granted at T with rst=1 at the same edge -> no m0_ack at T+1. Also rst high with requests pending -> bus_req=0 and both gnt=0.
- Mode passthrough: m1 half read (mode=01) at 0x6 -> bus_mode=01, bus_addr=0x6 exactly in the grant cycle.
